// File: rtl/ctrl_sd_pkg.sv
// ctrl_sd_pkg: register offsets, bytes, encodings for the SD read sequencer.
// Also holds the byte-wide CRC16-CCITT step used by sd_crc16.
package ctrl_sd_pkg;

    localparam logic [7:0] SPI_CS_OFS  = 8'h20;
    localparam logic [7:0] SPI_DAT_OFS = 8'h24;
    localparam logic [7:0] CMD17_BYTE  = 8'h51;
    localparam logic [7:0] START_TOKEN = 8'hFE;
    localparam logic [7:0] FILL_BYTE   = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CS_ON,
        S_PRE,
        S_CMD,
        S_R1,
        S_TOK,
        S_DATA,
        S_PUSH,
        S_CRC,
        S_CS_OFF,
        S_POST,
        S_FIN
    } state_e;

    // Sub-steps of one SPI byte exchange over qmem.
    typedef enum logic [1:0] {
        PH_WR,
        PH_RD,
        PH_CAP
    } phase_e;

    localparam logic [2:0] ERR_OK       = 3'd0;
    localparam logic [2:0] ERR_R1_TMO   = 3'd1;
    localparam logic [2:0] ERR_R1_BAD   = 3'd2;
    localparam logic [2:0] ERR_DATA_TOK = 3'd3;
    localparam logic [2:0] ERR_TOK_TMO  = 3'd4;
    localparam logic [2:0] ERR_CRC      = 3'd5;

    function automatic logic [15:0] crc16_step(
        input logic [15:0] crc,
        input logic [7:0]  din
    );
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ din[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// sd_crc16: byte-serial CRC16-CCITT (poly 0x1021, init 0) accumulator.
// clr wins over en; the result is registered.
module sd_crc16
    import ctrl_sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr)     crc_d = 16'h0000;
        else if (en) crc_d = crc16_step(crc_q, din);
    end

    always_ff @(posedge clk) begin
        if (rst) crc_q <= 16'h0000;
        else     crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/ctrl_sd_rd_seq.sv
// ctrl_sd_rd_seq: qmem master running one SPI-mode CMD17 block read.
// Define CTRL_SD_RD_SEQ_CRC_EN to verify the data CRC16 (err 5).
module ctrl_sd_rd_seq
    import ctrl_sd_pkg::*;
#(
    parameter int              QAW         = 22,
    parameter int              QDW         = 32,
    parameter int              QSW         = QDW / 8,
    parameter logic [QAW-1:0]  REG_BASE    = 22'h200000,
    parameter logic [3:0]      CS_SEL      = 4'b0001,
    parameter int              RESP_TRIES  = 8,
    parameter logic [15:0]     TOKEN_TRIES = 16'd50000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req,
    input  logic [31:0]    blk_addr,
    input  logic           sdhc,
    output logic           busy,
    output logic           done,
    output logic [2:0]     err_code,
    output logic [7:0]     out_dat,
    output logic           out_vld,
    input  logic           out_rdy,
    output logic [QAW-1:0] adr,
    output logic           cs,
    output logic           we,
    output logic [QSW-1:0] sel,
    output logic [QDW-1:0] dat_w,
    input  logic [QDW-1:0] dat_r,
    input  logic           ack,
    input  logic           err
);

    localparam logic [QAW-1:0] CS_ADR  = REG_BASE + QAW'(SPI_CS_OFS);
    localparam logic [QAW-1:0] DAT_ADR = REG_BASE + QAW'(SPI_DAT_OFS);

    state_e         state_q, state_d;
    phase_e         ph_q, ph_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [9:0]     bcnt_q, bcnt_d;
    logic [7:0]     rx_q, rx_d;
    logic [31:0]    arg_q, arg_d;
    logic [2:0]     err_q, err_d;
    logic [2:0]     err_code_q, err_code_d;
    logic           cs_q, cs_d;
    logic           we_q, we_d;
    logic [QAW-1:0] adr_q, adr_d;
    logic [QDW-1:0] dat_w_q, dat_w_d;

    logic       is_xfer, is_reg_wr;
    logic       xfer_done, wr_done;
    logic [7:0] rx_now, tx_byte, wr_byte;
    logic       unused_ok;

    assign unused_ok = ^{err, dat_r[QDW-1:8]};
    assign rx_now    = dat_r[7:0];
    assign is_reg_wr = state_q inside {S_CS_ON, S_CS_OFF};
    assign is_xfer   = state_q inside {S_PRE, S_CMD, S_R1, S_TOK,
                                       S_DATA, S_CRC, S_POST};

`ifdef CTRL_SD_RD_SEQ_CRC_EN
    logic [15:0] crc_val;

    sd_crc16 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (state_q == S_IDLE && req),
        .en  (state_q == S_DATA && xfer_done),
        .din (rx_now),
        .crc (crc_val)
    );
`endif

    always_comb begin
        tx_byte = FILL_BYTE;
        if (state_q == S_CMD) begin
            case (cnt_q[2:0])
                3'd0:    tx_byte = CMD17_BYTE;
                3'd1:    tx_byte = arg_q[31:24];
                3'd2:    tx_byte = arg_q[23:16];
                3'd3:    tx_byte = arg_q[15:8];
                3'd4:    tx_byte = arg_q[7:0];
                default: tx_byte = FILL_BYTE;
            endcase
        end
        wr_byte = (state_q == S_CS_ON) ? {CS_SEL, CS_SEL}
                                       : {CS_SEL, 4'b0000};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ph_q       <= PH_WR;
            cnt_q      <= '0;
            bcnt_q     <= '0;
            rx_q       <= '0;
            arg_q      <= '0;
            err_q      <= ERR_OK;
            err_code_q <= ERR_OK;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_w_q    <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            bcnt_q     <= bcnt_d;
            rx_q       <= rx_d;
            arg_q      <= arg_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_w_q    <= dat_w_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        bcnt_d     = bcnt_q;
        rx_d       = rx_q;
        arg_d      = arg_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        cs_d       = cs_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_w_d    = dat_w_q;
        xfer_done  = 1'b0;
        wr_done    = 1'b0;

        // One access at a time; cs drops for a cycle after every ack.
        if (is_xfer || is_reg_wr) begin
            if (cs_q) begin
                if (ack) begin
                    cs_d = 1'b0;
                    if (is_reg_wr)          wr_done = 1'b1;
                    else if (ph_q == PH_WR) ph_d = PH_RD;
                    else                    ph_d = PH_CAP;
                end
            end else if (ph_q == PH_CAP) begin
                ph_d      = PH_WR;
                xfer_done = 1'b1;
                rx_d      = rx_now;
            end else begin
                cs_d    = 1'b1;
                we_d    = is_reg_wr || (ph_q == PH_WR);
                adr_d   = is_reg_wr ? CS_ADR : DAT_ADR;
                dat_w_d = is_reg_wr ? QDW'(wr_byte) : QDW'(tx_byte);
            end
        end

        unique case (state_q)
            S_IDLE: if (req) begin
                state_d    = S_CS_ON;
                ph_d       = PH_WR;
                cnt_d      = '0;
                err_d      = ERR_OK;
                err_code_d = ERR_OK;
                arg_d      = sdhc ? blk_addr : {blk_addr[22:0], 9'b0};
            end
            S_CS_ON: if (wr_done) state_d = S_PRE;
            S_PRE: if (xfer_done) begin
                state_d = S_CMD;
                cnt_d   = '0;
            end
            S_CMD: if (xfer_done) begin
                if (cnt_q == 16'd5) begin
                    state_d = S_R1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_R1: if (xfer_done) begin
                if (!rx_now[7]) begin
                    if (rx_now == 8'h00) begin
                        state_d = S_TOK;
                        cnt_d   = '0;
                    end else begin
                        err_d   = ERR_R1_BAD;
                        state_d = S_CS_OFF;
                    end
                end else if (cnt_q == 16'(RESP_TRIES - 1)) begin
                    err_d   = ERR_R1_TMO;
                    state_d = S_CS_OFF;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TOK: if (xfer_done) begin
                if (rx_now == START_TOKEN) begin
                    state_d = S_DATA;
                    bcnt_d  = '0;
                end else if (rx_now == FILL_BYTE) begin
                    if (cnt_q == TOKEN_TRIES - 16'd1) begin
                        err_d   = ERR_TOK_TMO;
                        state_d = S_CS_OFF;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else begin
                    err_d   = ERR_DATA_TOK;
                    state_d = S_CS_OFF;
                end
            end
            S_DATA: if (xfer_done) state_d = S_PUSH;
            S_PUSH: if (out_rdy) begin
                if (bcnt_q != 10'd511) begin
                    bcnt_d  = bcnt_q + 10'd1;
                    state_d = S_DATA;
                end else begin
                    state_d = S_CRC;
                    cnt_d   = '0;
                end
            end
            // rx_q holds the first (MSB) CRC byte when the second lands.
            S_CRC: if (xfer_done) begin
                if (cnt_q == 16'd0) begin
                    cnt_d = 16'd1;
                end else begin
                    state_d = S_CS_OFF;
`ifdef CTRL_SD_RD_SEQ_CRC_EN
                    if ({rx_q, rx_now} != crc_val) err_d = ERR_CRC;
`endif
                end
            end
            S_CS_OFF: if (wr_done) state_d = S_POST;
            S_POST: if (xfer_done) begin
                state_d    = S_FIN;
                err_code_d = err_q;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = !(state_q inside {S_IDLE, S_FIN});
        done    = (state_q == S_FIN);
        out_vld = (state_q == S_PUSH);
        out_dat = rx_q;
    end

    assign err_code = err_code_q;
    assign cs       = cs_q;
    assign we       = we_q;
    assign adr      = adr_q;
    assign dat_w    = dat_w_q;
    assign sel      = '1;

endmodule

// File: tb/tb_ctrl_sd_rd_seq.sv
// tb_ctrl_sd_rd_seq: ctrl SPI register model plus behavioural SD card,
// scoreboarded byte stream and directed CMD17 scenarios.
`timescale 1ns/1ps
module tb_ctrl_sd_rd_seq;

    localparam int QAW = 22;
    localparam int QDW = 32;
    localparam int QSW = 4;
    localparam logic [QAW-1:0] CS_A  = 22'h200020;
    localparam logic [QAW-1:0] DAT_A = 22'h200024;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req = 1'b0;
    logic [31:0]    blk_addr = '0;
    logic           sdhc = 1'b0;
    logic           busy, done, out_vld;
    logic [2:0]     err_code;
    logic [7:0]     out_dat;
    logic           out_rdy = 1'b1;
    logic [QAW-1:0] adr;
    logic           cs, we;
    logic [QSW-1:0] sel;
    logic [QDW-1:0] dat_w, dat_r;
    logic           ack = 1'b0;
    logic           err = 1'b0;

    always #5 clk = ~clk;

    ctrl_sd_rd_seq dut (
        .clk(clk), .rst(rst), .req(req), .blk_addr(blk_addr),
        .sdhc(sdhc), .busy(busy), .done(done), .err_code(err_code),
        .out_dat(out_dat), .out_vld(out_vld), .out_rdy(out_rdy),
        .adr(adr), .cs(cs), .we(we), .sel(sel), .dat_w(dat_w),
        .dat_r(dat_r), .ack(ack), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;
    int n_rx = 0;
    int lat = 0;
    int rdy_mode = 0;
    int cmd_cnt = 0;
    int post_cmd = 0;

    logic [3:0] spi_cs_reg = 4'h0;
    logic [7:0] spi_rx = 8'hFF;
    logic [7:0] miso_q[$];
    logic [7:0] cmd_log[$];
    logic [7:0] cs_log[$];
    logic [7:0] exp_q[$];

    assign dat_r = {24'h0, spi_rx};

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [QAW-1:0] a,
                             input logic [7:0] d);
        if (a == CS_A) begin
            cs_log.push_back(d);
            spi_cs_reg = (spi_cs_reg & ~d[7:4]) | (d[3:0] & d[7:4]);
        end else if (a == DAT_A) begin
            spi_rx = 8'hFF;
            if (spi_cs_reg[0]) begin
                if (cmd_cnt < 6 && (cmd_cnt > 0 || d == 8'h51)) begin
                    cmd_log.push_back(d);
                    cmd_cnt++;
                end else if (cmd_cnt == 6) begin
                    post_cmd++;
                    if (miso_q.size() > 0) spi_rx = miso_q.pop_front();
                end
            end
        end
    endtask

    // qmem slave: ack after lat waiting cycles, effect applied after ack.
    initial begin
        logic [QAW-1:0] l_adr;
        logic           l_we;
        logic [7:0]     l_dat;
        int             wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ack) begin
                ack = 1'b0;
                wcnt = 0;
                if (l_we) bus_write(l_adr, l_dat);
            end else if (cs) begin
                if (wcnt >= lat) begin
                    ack   = 1'b1;
                    l_adr = adr;
                    l_we  = we;
                    l_dat = dat_w[7:0];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode != 0) begin
                ph = (ph + 1) % 6;
                out_rdy = (ph < 3);
            end else begin
                out_rdy = 1'b1;
            end
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (out_vld && out_rdy) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL stream_extra: got %0h, expected none",
                             out_dat);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_byte", {24'h0, out_dat}, {24'h0, e});
                end
            end
        end
    end

    function automatic logic [7:0] dbyte(input int pat, input int i);
        if (pat == 0) return 8'(i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic card_setup(input int r1_wait, input logic [7:0] r1,
                              input int tok_wait, input logic [7:0] tok,
                              input int pat, input bit bad_crc);
        logic [15:0] c;
        logic [7:0]  d;
        logic        fb;
        miso_q.delete();
        cmd_log.delete();
        cs_log.delete();
        exp_q.delete();
        cmd_cnt = 0;
        post_cmd = 0;
        n_rx = 0;
        repeat (r1_wait) miso_q.push_back(8'hFF);
        miso_q.push_back(r1);
        if (r1 == 8'h00) begin
            repeat (tok_wait) miso_q.push_back(8'hFF);
            miso_q.push_back(tok);
            if (tok == 8'hFE) begin
                c = 16'h0000;
                for (int i = 0; i < 512; i++) begin
                    d = dbyte(pat, i);
                    miso_q.push_back(d);
                    exp_q.push_back(d);
                    for (int b = 7; b >= 0; b--) begin
                        fb = c[15] ^ d[b];
                        c = {c[14:0], 1'b0};
                        if (fb) c = c ^ 16'h1021;
                    end
                end
                miso_q.push_back(bad_crc ? (c[15:8] ^ 8'h01) : c[15:8]);
                miso_q.push_back(c[7:0]);
            end
        end
    endtask

    task automatic check_cmd(input logic [31:0] arg);
        logic [7:0] exp_b[6];
        exp_b[0] = 8'h51;
        exp_b[1] = arg[31:24];
        exp_b[2] = arg[23:16];
        exp_b[3] = arg[15:8];
        exp_b[4] = arg[7:0];
        exp_b[5] = 8'hFF;
        check("cmd_len", cmd_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < cmd_log.size())
                check("cmd_byte", {24'h0, cmd_log[i]}, {24'h0, exp_b[i]});
        end
    endtask

    task automatic run(input logic [31:0] ba, input logic hc);
        int   k;
        logic gap;
        blk_addr = ba;
        sdhc = hc;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        check("busy_start", {31'h0, busy}, 1);
        check("err_clear", {29'h0, err_code}, 0);
        gap = 1'b0;
        k = 0;
        while (!done && k < 30000) begin
            if (!busy) gap = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        check("done_seen", {31'h0, done}, 1);
        check("busy_held", {31'h0, gap}, 0);
        check("busy_at_done", {31'h0, busy}, 0);
        @(posedge clk);
        #1;
        check("done_pulse", {31'h0, done}, 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_err", {29'h0, err_code}, 0);
        check("rst_vld", {31'h0, out_vld}, 0);
        check("rst_cs", {31'h0, cs}, 0);
        check("rst_we", {31'h0, we}, 0);
        check("rst_adr", {10'h0, adr}, 0);
        check("rst_datw", dat_w, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Byte addressing: block 3 -> argument 0x600.
        card_setup(2, 8'h00, 5, 8'hFE, 0, 0);
        run(32'd3, 1'b0);
        check_cmd(32'h0000_0600);
        check("t1_err", {29'h0, err_code}, 0);
        check("t1_drained", exp_q.size(), 0);
        check("t1_cs_n", cs_log.size(), 2);
        if (cs_log.size() == 2) begin
            check("t1_cs_on", {24'h0, cs_log[0]}, 32'h11);
            check("t1_cs_off", {24'h0, cs_log[1]}, 32'h10);
        end

        // Block addressing with slow SPI and a throttled sink.
        lat = 2;
        rdy_mode = 1;
        card_setup(0, 8'h00, 1, 8'hFE, 1, 0);
        run(32'h1234_5678, 1'b1);
        check_cmd(32'h1234_5678);
        check("t2_err", {29'h0, err_code}, 0);
        check("t2_drained", exp_q.size(), 0);
        check("t2_count", n_rx, 512);
        lat = 0;
        rdy_mode = 0;

        // Silent card: eight R1 polls then timeout.
        card_setup(0, 8'hFF, 0, 8'hFF, 0, 0);
        run(32'd5, 1'b1);
        check("t3_polls", post_cmd, 8);
        check("t3_err", {29'h0, err_code}, 1);
        check("t3_released", {31'h0, spi_cs_reg[0]}, 0);
        check("t3_no_data", n_rx, 0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_err_hold", {29'h0, err_code}, 1);

        card_setup(1, 8'h05, 0, 8'hFF, 0, 0);
        run(32'd7, 1'b1);
        check("t4_err_r1", {29'h0, err_code}, 2);
        check("t4_rel_r1", {31'h0, spi_cs_reg[0]}, 0);

        card_setup(0, 8'h00, 2, 8'h0B, 0, 0);
        run(32'd8, 1'b1);
        check("t4_err_tok", {29'h0, err_code}, 3);
        check("t4_rel_tok", {31'h0, spi_cs_reg[0]}, 0);
        check("t4_no_data", n_rx, 0);

        // Reset while fetching data byte 100.
        card_setup(0, 8'h00, 0, 8'hFE, 0, 0);
        blk_addr = 32'd9;
        sdhc = 1'b1;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        k = 0;
        while (n_rx < 100 && k < 30000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("t5_reached", n_rx, 100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_busy", {31'h0, busy}, 0);
        check("t5_vld", {31'h0, out_vld}, 0);
        check("t5_cs", {31'h0, cs}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t5_no_more", n_rx, 100);
        spi_cs_reg = 4'h0;
        card_setup(1, 8'h00, 3, 8'hFE, 1, 0);
        run(32'd10, 1'b1);
        check_cmd(32'd10);
        check("t5_err", {29'h0, err_code}, 0);
        check("t5_drained", exp_q.size(), 0);

        // Corrupted CRC byte.
        card_setup(0, 8'h00, 0, 8'hFE, 0, 1);
        run(32'd11, 1'b1);
        check("t6_drained", exp_q.size(), 0);
`ifdef CTRL_SD_RD_SEQ_CRC_EN
        check("t6_crc_bad", {29'h0, err_code}, 5);
        card_setup(0, 8'h00, 0, 8'hFE, 1, 0);
        run(32'd12, 1'b1);
        check("t6_crc_ok", {29'h0, err_code}, 0);
`else
        check("t6_crc_ignored", {29'h0, err_code}, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_sd_rd_seq.md
Name: ctrl_sd_rd_seq

Overview:
Hardware sequencer that performs one SD-card single-block read (CMD17, SPI mode) on request. It drives the ctrl register block's SPI registers as a qmem bus master, in place of CPU polling. The 512 data bytes leave on a byte stream with valid/ready backpressure. It sits between the ctrl CPU's qmem master mux and the ctrl register slave.

Parameters:
QAW, 22, qmem address width
QDW, 32, qmem data width
QSW, QDW/8, qmem select width
REG_BASE, 22'h200000, word address of the ctrl register block (SPI_CS at +0x20, SPI_DAT at +0x24)
CS_SEL, 4'b0001, one-hot SPI chip-select used for the card
RESP_TRIES, 8, max R1 polling bytes
TOKEN_TRIES, 16'd50000, max start-token polling bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  1  start pulse; sampled only in IDLE
blk_addr  in  32  block number
sdhc  in  1  1 = block addressing; 0 = byte addressing (argument = blk_addr<<9, low 32 bits)
busy  out  1  high from the cycle after accepted req until done
done  out  1  one-cycle pulse at end, success or error
err_code  out  3  0 ok, 1 R1 timeout, 2 R1 nonzero, 3 data error token, 4 token timeout, 5 CRC mismatch
out_dat  out  8  data byte
out_vld  out  1  data valid
out_rdy  in  1  sink ready
adr  out  QAW  qmem address
cs  out  1  qmem chip select
we  out  1  qmem write enable
sel  out  QSW  byte selects; always all ones
dat_w  out  QDW  write data
dat_r  in  QDW  read data
ack  in  1  qmem acknowledge
err  in  1  qmem error; ignored

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, err_code=0, out_vld=0, cs=0, we=0, adr=0, dat_w=0.
- qmem access: cs/we/adr/dat_w stay stable until the cycle with cs&&ack, which completes the access. For reads, dat_r is sampled in the cycle after the ack cycle.
- Byte xfer primitive XFER(b) = write b to SPI_DAT (ack stalls while SPI is busy), then read SPI_DAT and capture dat_r[7:0] as rx.
- States, in order: IDLE, CS_ON, PRE, CMD, R1, TOK, DATA, PUSH, CRC, CS_OFF, POST, FIN.
- IDLE: when req=1, latch the argument and go to CS_ON.
- CS_ON: write SPI_CS = {CS_SEL, CS_SEL} (masked assert).
- PRE: XFER(0xFF) once.
- CMD: six XFERs in order: 0x51, arg[31:24], arg[23:16], arg[15:8], arg[7:0], 0xFF. rx is discarded.
- R1: XFER(0xFF) until rx[7]=0.
  - rx=0x00 goes to TOK.
  - Any other value with rx[7]=0 sets err 2 and goes to CS_OFF.
  - After RESP_TRIES bytes without rx[7]=0, set err 1.
- TOK: XFER(0xFF).
  - rx=0xFE goes to DATA.
  - rx=0xFF repeats.
  - Any other rx sets err 3.
  - After TOKEN_TRIES bytes, set err 4.
- DATA: XFER(0xFF), then PUSH.
- PUSH: out_vld=1 with out_dat=rx, held until out_rdy. Next state is DATA while the 10-bit count < 511, else CRC. No SPI access occurs while PUSH is stalled.
- CRC: two XFER(0xFF).
- CS_OFF: write SPI_CS = {CS_SEL, 4'b0000}. Reached on every path, including errors.
- POST: XFER(0xFF), giving 8 trailing clocks.
- FIN: done=1 for one cycle, err_code updated, busy=0, return to IDLE.
- err_code holds until the next accepted req, which clears it.
- A req arriving while busy is ignored.
- On error, no further bytes are pushed. Bytes already pushed are valid.
- rst mid-operation: return to IDLE and drop cs/out_vld immediately. SPI chip-select is not restored; the CPU must rewrite SPI_CS.

Optional Feature:
Macro: CTRL_SD_RD_SEQ_CRC_EN.
- Defined: CRC16-CCITT (poly 0x1021, init 0) is computed over the 512 data bytes and compared with the two received CRC bytes, MSB first. A mismatch sets err 5; data has already been streamed.
- Undefined: CRC bytes are clocked and discarded, and err 5 never occurs.

Decomposition:
- Package ctrl_sd_pkg: SPI register offsets (SPI_CS 0x20, SPI_DAT 0x24), CMD17 byte 0x51, start token 0xFE, state encoding, err_code constants.
- Sub-module sd_crc16: byte-wide CRC16-CCITT with clr/en/din/crc; instantiated only under the macro.

Test Plan:
- Bench setup: ctrl regs block instance plus behavioural SD model.
- sdhc=0, blk_addr=3, card returns R1=0x00 after 2 bytes, token after 5, data i&0xFF -> CMD bytes 51 00 00 06 00 FF; 512 bytes 00..FF twice on the stream; done with err 0; SPI_CS writes 0x11 then 0x10.
- sdhc=1, blk_addr=0x12345678, out_rdy toggled every 3 cycles -> argument bytes 12 34 56 78; no byte lost or duplicated; busy high throughout.
- Card never responds (MISO all 0xFF) -> exactly 8 R1 polls; err 1; CS released; no out_vld.
- R1=0x05 -> err 2. Token 0x0B -> err 3. Both after CS release.
- Assert rst during DATA byte 100 -> next cycle busy=0, out_vld=0, cs=0; a new req completes normally after the CPU rewrites SPI_CS.
- With CTRL_SD_RD_SEQ_CRC_EN, corrupt one CRC byte -> err 5. Correct CRC -> err 0.
